lm32_interrupt_ctrl: RTL and testbench

- Parametrised next-generation LM32 interrupt controller.
- Sits between the external interrupt pins and the pipeline, alongside the other CSR blocks, and serves the IE, IM and IP CSRs plus a new ICFG CSR.
- Adds the following over the current controller:
  - channel count from 1 to 32;
  - input synchronisers;
  - a per-channel edge or level mode;
  - a registered, priority-encoded vector output for software dispatch.

---
 rtl/lm32_interrupt_ctrl.sv | 131 +++++++++++++
 tb/tb_lm32_interrupt_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lm32_interrupt_ctrl.sv
// LM32 interrupt controller: synchronised pins, per-channel edge/level capture,
// IE/IM/IP/ICFG CSRs and a registered priority-encoded dispatch vector.
module lm32_interrupt_ctrl #(
    parameter int                    INTERRUPTS  = 32,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [INTERRUPTS-1:0] EDGE_RESET  = '0,
    parameter logic [4:0]            ICFG_CSR    = 5'h14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INTERRUPTS-1:0] interrupt_n,
    input  logic                  stall_x,
    input  logic                  non_debug_exception,
    input  logic                  debug_exception,
    input  logic                  eret_q_x,
    input  logic                  bret_q_x,
    input  logic [4:0]            csr,
    input  logic [31:0]           csr_write_data,
    input  logic                  csr_write_enable,
    output logic [31:0]           csr_read_data,
    output logic                  interrupt_exception,
    output logic [4:0]            interrupt_vector,
    output logic                  interrupt_vector_valid
);

    localparam logic [4:0] IE_CSR = 5'h00;
    localparam logic [4:0] IM_CSR = 5'h01;
    localparam logic [4:0] IP_CSR = 5'h02;

    logic [INTERRUPTS-1:0] lvl, prev, rise, ip, im, icfg, clr, chg, pend, ip_next;
    logic [INTERRUPTS-1:0] wdata;
    logic                  ie, eie, bie, wr_ok;
    logic [4:0]            vec_next;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign lvl = ~interrupt_n;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][INTERRUPTS-1:0] sync;
            // Flops reset to the deasserted (high) pin level.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    sync <= '1;
                end else begin
                    sync[0] <= interrupt_n;
                    for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
                end
            end
            assign lvl = ~sync[SYNC_STAGES-1];
        end
    endgenerate

    assign wdata = csr_write_data[INTERRUPTS-1:0];
    assign wr_ok = csr_write_enable & ~stall_x & ~non_debug_exception & ~debug_exception
                 & ~eret_q_x & ~bret_q_x;
    assign rise  = lvl & ~prev;
    assign clr   = (wr_ok && csr == IP_CSR) ? wdata : '0;
    assign chg   = (wr_ok && csr == ICFG_CSR) ? (wdata ^ icfg) : '0;
    assign pend  = ip & im;

    // A mode change flushes the channel; otherwise a rise beats a same-cycle clear.
    always_comb begin
        ip_next = '0;
        for (int c = 0; c < INTERRUPTS; c++) begin
            if (chg[c])       ip_next[c] = 1'b0;
            else if (icfg[c]) ip_next[c] = rise[c] | (ip[c] & ~clr[c]);
            else              ip_next[c] = lvl[c];
        end
    end

    always_comb begin
        vec_next = interrupt_vector;
        for (int i = INTERRUPTS - 1; i >= 0; i--) begin
            if (pend[i]) vec_next = 5'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prev                   <= '1;
            ip                     <= '0;
            im                     <= '0;
            icfg                   <= EDGE_RESET;
            interrupt_vector       <= '0;
            interrupt_vector_valid <= 1'b0;
        end else begin
            prev                   <= lvl;
            ip                     <= ip_next;
            interrupt_vector       <= vec_next;
            interrupt_vector_valid <= |pend;
            if (wr_ok && csr == IM_CSR)   im   <= wdata;
            if (wr_ok && csr == ICFG_CSR) icfg <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ie  <= 1'b0;
            eie <= 1'b0;
            bie <= 1'b0;
        end else if (non_debug_exception) begin
            eie <= ie;
            ie  <= 1'b0;
        end else if (debug_exception) begin
            bie <= ie;
            ie  <= 1'b0;
        end else if (!stall_x) begin
            if (eret_q_x)                     ie <= eie;
            else if (bret_q_x)                ie <= bie;
            else if (wr_ok && csr == IE_CSR) begin
                ie  <= csr_write_data[0];
                eie <= csr_write_data[1];
                bie <= csr_write_data[2];
            end
        end
    end

    assign interrupt_exception = ie & |pend;

    always_comb begin
        csr_read_data = '0;
        case (csr)
            IE_CSR:   csr_read_data = {29'b0, bie, eie, ie};
            IM_CSR:   csr_read_data = 32'(im);
            IP_CSR:   csr_read_data = 32'(ip);
            ICFG_CSR: csr_read_data = 32'(icfg);
            default:  csr_read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_lm32_interrupt_ctrl.sv
// Directed and randomised checks of lm32_interrupt_ctrl against a behavioural model.
module tb_lm32_interrupt_ctrl;

    localparam int         N    = 32;
    localparam int         S    = 2;
    localparam logic [4:0] ICFG = 5'h14;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] interrupt_n;
    logic        stall_x, non_debug_exception, debug_exception, eret_q_x, bret_q_x;
    logic [4:0]  csr;
    logic [31:0] csr_write_data;
    logic        csr_write_enable;
    logic [31:0] csr_read_data;
    logic        interrupt_exception;
    logic [4:0]  interrupt_vector;
    logic        interrupt_vector_valid;

    lm32_interrupt_ctrl #(.INTERRUPTS(N), .SYNC_STAGES(S), .EDGE_RESET('0), .ICFG_CSR(ICFG)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .interrupt_n(interrupt_n), .stall_x(stall_x),
        .non_debug_exception(non_debug_exception), .debug_exception(debug_exception),
        .eret_q_x(eret_q_x), .bret_q_x(bret_q_x), .csr(csr), .csr_write_data(csr_write_data),
        .csr_write_enable(csr_write_enable), .csr_read_data(csr_read_data),
        .interrupt_exception(interrupt_exception), .interrupt_vector(interrupt_vector),
        .interrupt_vector_valid(interrupt_vector_valid)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: the pin is seen S cycles late; a channel is "pending"
    // per its mode; dispatch picks the lowest pending unmasked channel.
    bit          m_ie, m_eie, m_bie, m_vld;
    logic [31:0] m_im, m_ip, m_icfg, m_prev;
    logic [4:0]  m_vec;
    logic [31:0] pin_hist[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = 0; m_eie = 0; m_bie = 0; m_vld = 0;
        m_im = 0; m_ip = 0; m_icfg = 0; m_prev = '1; m_vec = 0;
        pin_hist.delete();
        for (int i = 0; i < S; i++) pin_hist.push_back('1);
    endtask

    task automatic model_step();
        logic [31:0] asserted, ip_n;
        bit accepted;
        bit started;
        asserted = ~pin_hist[0];
        accepted = csr_write_enable && !stall_x && !non_debug_exception && !debug_exception
                   && !eret_q_x && !bret_q_x;
        ip_n = m_ip;
        for (int c = 0; c < N; c++) begin
            started = asserted[c] && !m_prev[c];
            if (accepted && csr == ICFG && csr_write_data[c] != m_icfg[c]) ip_n[c] = 0;
            else if (!m_icfg[c])                                         ip_n[c] = asserted[c];
            else if (started)                                            ip_n[c] = 1;
            else if (accepted && csr == 5'h02 && csr_write_data[c])      ip_n[c] = 0;
        end
        m_vld = 0;
        for (int c = 0; c < N; c++) begin
            if (m_ip[c] && m_im[c]) begin
                m_vec = 5'(c);
                m_vld = 1;
                break;
            end
        end
        if (non_debug_exception) begin m_eie = m_ie; m_ie = 0; end
        else if (debug_exception) begin m_bie = m_ie; m_ie = 0; end
        else if (!stall_x) begin
            if (eret_q_x) m_ie = m_eie;
            else if (bret_q_x) m_ie = m_bie;
            else if (accepted && csr == 5'h00) begin
                m_ie = csr_write_data[0]; m_eie = csr_write_data[1]; m_bie = csr_write_data[2];
            end
        end
        if (accepted && csr == 5'h01) m_im = csr_write_data;
        if (accepted && csr == ICFG)  m_icfg = csr_write_data;
        m_ip = ip_n;
        m_prev = asserted;
        void'(pin_hist.pop_front());
        pin_hist.push_back(interrupt_n);
    endtask

    function automatic logic [31:0] exp_read();
        case (csr)
            5'h00:   return {29'b0, m_bie, m_eie, m_ie};
            5'h01:   return m_im;
            5'h02:   return m_ip;
            ICFG:    return m_icfg;
            default: return 32'h0;
        endcase
    endfunction

    task automatic compare_all(string tag);
        check({tag, ".rd"},  csr_read_data,          exp_read());
        check({tag, ".exc"}, interrupt_exception,    32'(m_ie && (m_ip & m_im) != 0));
        check({tag, ".vec"}, interrupt_vector,       m_vec);
        check({tag, ".vld"}, interrupt_vector_valid, m_vld);
    endtask

    task automatic step(string tag);
        model_step();
        @(posedge clk_i);
        #1;
        compare_all(tag);
    endtask

    task automatic wr(logic [4:0] idx, logic [31:0] data);
        csr = idx; csr_write_data = data; csr_write_enable = 1;
        step("wr");
        csr_write_enable = 0;
    endtask

    task automatic check_reset_state(string tag);
        csr = 5'h00; #1; check({tag, ".ie"},   csr_read_data, 32'h0);
        csr = 5'h01; #1; check({tag, ".im"},   csr_read_data, 32'h0);
        csr = 5'h02; #1; check({tag, ".ip"},   csr_read_data, 32'h0);
        csr = ICFG;  #1; check({tag, ".icfg"}, csr_read_data, 32'h0);
        check({tag, ".exc"}, interrupt_exception, 0);
        check({tag, ".vec"}, interrupt_vector, 0);
        check({tag, ".vld"}, interrupt_vector_valid, 0);
    endtask

    initial begin
        rst_i = 0; interrupt_n = '1; stall_x = 0; non_debug_exception = 0; debug_exception = 0;
        eret_q_x = 0; bret_q_x = 0; csr = 0; csr_write_data = 0; csr_write_enable = 0;
        model_reset();
        #2;
        check_reset_state("reset");
        @(negedge clk_i);
        rst_i = 1;

        // Edge channel 3, one-cycle pulse.
        wr(ICFG, 32'h8); wr(5'h01, 32'h8); wr(5'h00, 32'h1);
        csr = 5'h02;
        interrupt_n[3] = 0; step("e3a");
        interrupt_n[3] = 1; step("e3b");
        check("ip3_early", csr_read_data[3], 0);
        step("e3c");
        check("ip3_lat", csr_read_data[3], 1);
        check("exc3", interrupt_exception, 1);
        step("e3d");
        check("vec3", interrupt_vector, 3);
        check("vld3", interrupt_vector_valid, 1);
        wr(5'h02, 32'h8);
        check("ip3_clr", csr_read_data[3], 0);
        check("exc3_drop", interrupt_exception, 0);

        // Level channel 5 held: clear has no lasting effect.
        wr(5'h01, 32'h20);
        interrupt_n[5] = 0;
        repeat (3) step("l5");
        wr(5'h02, 32'h20);
        csr = 5'h02; #1;
        check("ip5_resets", csr_read_data[5], 1);
        interrupt_n[5] = 1;
        step("l5r"); step("l5r");
        check("ip5_hold", csr_read_data[5], 1);
        step("l5r");
        check("ip5_rel", csr_read_data[5], 0);

        // Priority: channels 2 and 7 (level).
        wr(5'h01, 32'h84);
        interrupt_n[2] = 0; interrupt_n[7] = 0;
        repeat (4) step("p27");
        check("vec2", interrupt_vector, 2);
        wr(5'h01, 32'h80);
        step("p7");
        check("vec7", interrupt_vector, 7);
        interrupt_n[2] = 1; interrupt_n[7] = 1;
        repeat (4) step("p27r");

        // Exception beats a write; eret honours stall.
        wr(5'h00, 32'h1);
        non_debug_exception = 1; csr = 5'h00; csr_write_data = 32'h1; csr_write_enable = 1;
        step("nde");
        non_debug_exception = 0; csr_write_enable = 0;
        check("nde_ie", csr_read_data, 32'h2);
        eret_q_x = 1; stall_x = 1; step("eret_st");
        check("eret_stall", csr_read_data, 32'h2);
        stall_x = 0; step("eret");
        eret_q_x = 0;
        check("eret_ie", csr_read_data, 32'h3);

        // Rise beats same-cycle clear; mode change flushes.
        wr(ICFG, 32'h9);
        interrupt_n[0] = 0; step("r0"); step("r0");
        wr(5'h02, 32'h1);
        csr = 5'h02; #1;
        check("ip0_rise_wins", csr_read_data[0], 1);
        interrupt_n[0] = 1;
        wr(ICFG, 32'h8);
        csr = 5'h02; #1;
        check("ip0_mode_flush", csr_read_data[0], 0);

        // Randomised traffic with one asynchronous mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            interrupt_n      = interrupt_n ^ ($urandom & $urandom & $urandom);
            csr_write_enable = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: csr = 5'h00;
                1: csr = 5'h01;
                2: csr = 5'h02;
                3: csr = ICFG;
                default: csr = 5'($urandom);
            endcase
            csr_write_data      = $urandom;
            stall_x             = ($urandom_range(0, 3) == 0);
            non_debug_exception = ($urandom_range(0, 15) == 0);
            debug_exception     = ($urandom_range(0, 15) == 0);
            eret_q_x            = ($urandom_range(0, 15) == 0);
            bret_q_x            = ($urandom_range(0, 15) == 0);
            step("rnd");
            if (i == 700) begin
                rst_i = 0;
                interrupt_n = '1; csr_write_enable = 0; non_debug_exception = 0;
                debug_exception = 0; eret_q_x = 0; bret_q_x = 0; stall_x = 0;
                model_reset();
                check_reset_state("midreset");
                @(negedge clk_i);
                rst_i = 1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
